// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default baud divisor, parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // 50 MHz system clock / 9600 baud
  localparam int unsigned BaudDivDefault = 5208;

  // Even parity is the plain XOR of the data; odd parity inverts it.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Baud-rate counter: counts 0..BAUD_DIV-1 while enabled, tick on the last count.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BaudDivDefault
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i && (cnt_q == CntMax);

  // Next count: clear has priority, wrap to zero right after the tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = BaudDivDefault,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_o,
  output logic       tx_busy_o,
  output logic       tx_done_o
);

  localparam logic LastStop = (STOP_BITS >= 2) ? 1'b1 : 1'b0;

  uart_state_e state_q;
  logic [7:0]  shift_q;
  logic        parity_q;
  logic [2:0]  bit_idx_q;
  logic        stop_idx_q;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;

  logic tick;
  logic accept;

  assign accept = (state_q == StIdle) && tx_start_i;

  baud_tick_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick_gen (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable_i (state_q != StIdle),
    .clear_i  (accept),
    .tick_o   (tick)
  );

  // Frame sequencer; tx/busy/done are registered alongside the state so each
  // changes on the edge that enters the new state or bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tx_start_i) begin
            state_q    <= StStart;
            shift_q    <= tx_data_i;
            parity_q   <= parity_bit(tx_data_i, PARITY_ODD);
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StStart: begin
          if (tick) begin
            state_q   <= StData;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_idx_q <= '0;
          end
        end
        StData: begin
          if (tick) begin
            if (bit_idx_q != 3'd7) begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 3'd1;
            end else if (PARITY_EN) begin
              state_q <= StParity;
              tx_q    <= parity_q;
            end else begin
              state_q    <= StStop;
              tx_q       <= 1'b1;
              stop_idx_q <= 1'b0;
            end
          end
        end
        StParity: begin
          if (tick) begin
            state_q    <= StStop;
            tx_q       <= 1'b1;
            stop_idx_q <= 1'b0;
          end
        end
        StStop: begin
          if (tick) begin
            if (stop_idx_q == LastStop) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_o      = tx_q;
  assign tx_busy_o = busy_q;
  assign tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: four configurations driven in parallel and
// compared every cycle against a frame-level reference model.
module tb_uart_tx_sequencer;

  localparam int Baud = 16;
  localparam int NCfg = 4;

  logic       clk;
  logic       rst_n;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] tx;
  logic [3:0] busy;
  logic [3:0] done;

  int n_tests = 0;
  int n_fail  = 0;

  // Config c: parity enable, odd parity, stop bits.
  // 0: none/1 stop, 1: even/1 stop, 2: odd/2 stop, 3: none/2 stop
  function automatic bit cfg_par(input int c);
    return (c == 1) || (c == 2);
  endfunction
  function automatic bit cfg_odd(input int c);
    return (c == 2);
  endfunction
  function automatic int cfg_stop(input int c);
    return (c >= 2) ? 2 : 1;
  endfunction

  uart_tx_sequencer #(.BAUD_DIV(Baud), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .tx_start_i(tx_start), .tx_data_i(tx_data),
    .tx_o(tx[0]), .tx_busy_o(busy[0]), .tx_done_o(done[0]));
  uart_tx_sequencer #(.BAUD_DIV(Baud), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .tx_start_i(tx_start), .tx_data_i(tx_data),
    .tx_o(tx[1]), .tx_busy_o(busy[1]), .tx_done_o(done[1]));
  uart_tx_sequencer #(.BAUD_DIV(Baud), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .tx_start_i(tx_start), .tx_data_i(tx_data),
    .tx_o(tx[2]), .tx_busy_o(busy[2]), .tx_done_o(done[2]));
  uart_tx_sequencer #(.BAUD_DIV(Baud), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .tx_start_i(tx_start), .tx_data_i(tx_data),
    .tx_o(tx[3]), .tx_busy_o(busy[3]), .tx_done_o(done[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame is a list of bit values, each held Baud clocks.
  bit          m_busy  [NCfg];
  bit          m_done  [NCfg];
  int          m_pos   [NCfg];
  int          m_len   [NCfg];
  logic [11:0] m_frame [NCfg];
  int          busy_cnt[NCfg];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCfg; c++) begin
      m_busy[c] = 1'b0;
      m_done[c] = 1'b0;
      m_pos[c]  = 0;
    end
  endtask

  task automatic model_accept(input int c, input logic [7:0] d);
    int k;
    m_frame[c] = '1;
    m_frame[c][0] = 1'b0;
    for (int i = 0; i < 8; i++) m_frame[c][1+i] = d[i];
    k = 9;
    if (cfg_par(c)) begin
      m_frame[c][9] = (^d) ^ cfg_odd(c);
      k = 10;
    end
    m_len[c]  = k + cfg_stop(c);
    m_busy[c] = 1'b1;
    m_pos[c]  = 0;
  endtask

  // Advance the model by one rising edge using the current inputs.
  task automatic model_step();
    for (int c = 0; c < NCfg; c++) begin
      m_done[c] = 1'b0;
      if (!m_busy[c]) begin
        if (tx_start) model_accept(c, tx_data);
      end else begin
        m_pos[c]++;
        if (m_pos[c] == m_len[c] * Baud) begin
          m_busy[c] = 1'b0;
          m_done[c] = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [3:0] exp_tx();
    logic [3:0] v;
    for (int c = 0; c < NCfg; c++)
      v[c] = m_busy[c] ? m_frame[c][m_pos[c] / Baud] : 1'b1;
    return v;
  endfunction
  function automatic logic [3:0] exp_busy();
    logic [3:0] v;
    for (int c = 0; c < NCfg; c++) v[c] = m_busy[c];
    return v;
  endfunction
  function automatic logic [3:0] exp_done();
    logic [3:0] v;
    for (int c = 0; c < NCfg; c++) v[c] = m_done[c];
    return v;
  endfunction

  // One clock: drive at negedge, edge, then compare at the next negedge.
  task automatic cycle(input logic start, input logic [7:0] data);
    tx_start = start;
    tx_data  = data;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
    check_eq("tx", tx, exp_tx());
    check_eq("busy", busy, exp_busy());
    check_eq("done", done, exp_done());
    for (int c = 0; c < NCfg; c++) busy_cnt[c] += int'(busy[c]);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  // Reset asserted between edges must clear outputs immediately.
  task automatic async_reset();
    @(posedge clk);
    model_step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_tx", tx, 4'hF);
    check_eq("rst_busy", busy, 4'h0);
    check_eq("rst_done", done, 4'h0);
    model_reset();
    @(negedge clk);
    cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h00);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset_tx", tx, 4'hF);
    check_eq("reset_busy", busy, 4'h0);
    check_eq("reset_done", done, 4'h0);
    rst_n = 1'b1;

    // 0x55 frame accepted on the first edge out of reset; measure frame length.
    for (int c = 0; c < NCfg; c++) busy_cnt[c] = 0;
    cycle(1'b1, 8'h55);
    idle_cycles(200);
    check_eq("len_cfg0", busy_cnt[0], 160);
    check_eq("len_cfg1", busy_cnt[1], 176);
    check_eq("len_cfg2", busy_cnt[2], 192);
    check_eq("len_cfg3", busy_cnt[3], 176);

    // Parity of 0x07: 1 when even, 0 when odd; sampled mid parity bit.
    cycle(1'b1, 8'h07);
    idle_cycles(150);
    check_eq("parity_even", tx[1], 1'b1);
    check_eq("parity_odd", tx[2], 1'b0);
    idle_cycles(60);

    // Start held high: 0xA3 then 0x3C, back to back.
    cycle(1'b1, 8'hA3);
    for (int i = 0; i < 200; i++) cycle(1'b1, 8'h3C);
    idle_cycles(200);

    // Second request mid-frame is ignored.
    cycle(1'b1, 8'h96);
    idle_cycles(49);
    cycle(1'b1, 8'h21);
    idle_cycles(150);

    // Reset at clock 70 of a frame, then a clean 0xFF frame.
    cycle(1'b1, 8'h5A);
    idle_cycles(69);
    async_reset();
    cycle(1'b1, 8'hFF);
    idle_cycles(200);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) async_reset();
      else cycle(($urandom_range(0, 7) == 0), 8'($urandom));
    end
    idle_cycles(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
